flopenr_32: RTL and testbench



---
 rtl/flopenr_32.sv | 54 +++++
 tb/tb_flopenr_32.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/flopenr_32.sv
// Load-enabled register with asynchronous active-high reset; Q is purely registered.
// Optional FLOPENR_32_PARITY_EN adds a registered even-parity output Q_par.
module flopenr_32 #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
`ifdef FLOPENR_32_PARITY_EN
  ,
  output logic             Q_par
`endif
);

  logic [WIDTH-1:0] q_q, q_d;

  // Only an enable of exactly 1 selects the new data; anything else holds.
  always_comb begin
    q_d = q_q;
    if (E == 1'b1) q_d = D;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= RESET_VALUE;
    else       q_q <= q_d;
  end

  assign Q = q_q;

`ifdef FLOPENR_32_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic par_q, par_d;

  // Parity is registered alongside the data so both change on the same edge.
  always_comb begin
    par_d = par_q;
    if (E == 1'b1) par_d = even_parity(D);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= even_parity(RESET_VALUE);
    else       par_q <= par_d;
  end

  assign Q_par = par_q;
`endif

endmodule

// File: tb/tb_flopenr_32.sv
// Self-checking bench for flopenr_32: directed scenarios followed by randomized
// enable/data/reset traffic checked against a behavioural register model.
module tb_flopenr_32;

  logic        clk;
  logic        reset;
  logic        E;
  logic [31:0] D;
  logic [31:0] Q;
`ifdef FLOPENR_32_PARITY_EN
  logic        Q_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the value the register should hold.
  logic [31:0] exp_q;

  flopenr_32 dut (
    .clk   (clk),
    .reset (reset),
    .E     (E),
    .D     (D),
    .Q     (Q)
`ifdef FLOPENR_32_PARITY_EN
    ,
    .Q_par (Q_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_par(input string tag, input logic [31:0] val);
`ifdef FLOPENR_32_PARITY_EN
    // Expected parity: odd number of ones means Q_par=1.
    check_eq(tag, {31'b0, Q_par}, {31'b0, 1'($countones(val) % 2)});
`endif
  endtask

  initial begin
    reset = 1'b1;
    E     = 1'b0;
    D     = 32'd94;
    exp_q = '0;

    // Reset held across an edge, then released at a falling edge.
    @(posedge clk); #1;
    check_eq("reset_hold", Q, 32'd0);
    check_par("reset_par", 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2 check_eq("rst_release_low", Q, 32'd0);
    @(negedge clk); #1;
    check_eq("falling_edge", Q, 32'd0);

    // E=0 across a rising edge.
    @(posedge clk); #2;
    check_eq("hold_disabled", Q, 32'd0);

    // Load on enable: nothing changes before the rising edge.
    @(negedge clk); #1;
    E = 1'b1; D = 32'd94;
    #1 check_eq("no_early_load", Q, 32'd0);
    @(posedge clk); #2;
    check_eq("load_94", Q, 32'd94);

    // Hold for three edges while D is all ones.
    @(negedge clk);
    E = 1'b0; D = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check_eq("hold_after_load", Q, 32'd94);
    end

    // Asynchronous reset in the high phase, then held across an enabled edge.
    @(negedge clk);
    E = 1'b1; D = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    check_eq("load_deadbeef", Q, 32'hDEAD_BEEF);
    reset = 1'b1;
    #1 check_eq("async_reset", Q, 32'd0);
    check_par("async_reset_par", 32'd0);
    D = 32'd5;
    @(posedge clk); #2;
    check_eq("reset_beats_enable", Q, 32'd0);
    @(negedge clk);
    reset = 1'b0; E = 1'b0;

    // Full-width patterns with parity.
    @(negedge clk);
    E = 1'b1; D = 32'hA5A5_A5A5;
    @(posedge clk); #2;
    check_eq("load_a5", Q, 32'hA5A5_A5A5);
`ifdef FLOPENR_32_PARITY_EN
    check_eq("par_a5", {31'b0, Q_par}, 32'd0);
`endif
    @(negedge clk);
    D = 32'h0000_0001;
    @(posedge clk); #2;
    check_eq("load_one", Q, 32'h0000_0001);
`ifdef FLOPENR_32_PARITY_EN
    check_eq("par_one", {31'b0, Q_par}, 32'd1);
`endif
    exp_q = 32'h0000_0001;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      check_eq("rand_falling", Q, exp_q);
      E = 1'($urandom_range(0, 1));
      D = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        exp_q = '0;
        #1 check_eq("rand_async_reset", Q, exp_q);
        reset = 1'b0;
      end
      @(posedge clk);
      if (E) exp_q = D;
      #2 check_eq("rand_edge", Q, exp_q);
      check_par("rand_par", exp_q);
      // Disturb inputs between edges; Q must not move.
      E = 1'($urandom_range(0, 1));
      D = $urandom;
      #1 check_eq("rand_mid_high", Q, exp_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
